// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one 32-bit ALU between two requesters.
// A request is granted in IDLE and its operands are registered. The ALU
// result is computed in EXEC. The tagged result is held in RESP until the
// consumer accepts it.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   req0/req1             requests, held with operands until granted
//   sel0/sel1, a0/b0/a1/b1  op code and operands per requester
//   gnt0/gnt1             combinational grant (operands captured on that edge)
//   busy                  high whenever the block is not idle
//   res_valid/res_id/res_data  registered result, owner index and data
//   res_ready             consumer accepts the result when res_valid is high
module alu_share_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  sel0,
  input  logic [2:0]  sel1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic        res_valid,
  output logic        res_id,
  output logic [31:0] res_data,
  input  logic        res_ready
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 3;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  logic [SW-1:0] op_sel;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          last_id;

  logic          any_req;
  logic          win_id;
  logic          grant_ok;
  logic          is_pow2;
  logic [DW-1:0] alu_out;

  // Arbitration: a lone request wins; a tie goes to requester 0 under fixed
  // priority, otherwise to the requester not served last.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      win_id = FIXED_PRIO ? 1'b0 : ~last_id;
    end else begin
      win_id = req1;
    end
    // Grants are gated by reset so nothing is offered while the block is held.
    grant_ok = reset && (state == IDLE) && any_req;
    gnt0     = grant_ok && !win_id;
    gnt1     = grant_ok && win_id;
  end

  assign busy = (state != IDLE);

  // Internal ALU working from the captured operands.
  always_comb begin
    // Power of two within bits [30:0]: nonzero and a single bit set.
    is_pow2 = !op_a[DW-1] && (op_a != '0) && ((op_a & (op_a - DW'(1))) == '0);
    alu_out = '0;
    case (op_sel)
      3'b000:  alu_out = op_a + op_b;
      3'b001:  alu_out = op_a - op_b;
      3'b010:  alu_out = op_a | op_b;
      3'b011:  alu_out = DW'(op_a == op_b);
      3'b100:  alu_out = op_a & op_b;
      3'b101:  alu_out = DW'(is_pow2);
      default: alu_out = '0;
    endcase
  end

  // Control FSM with registered operands and result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_sel    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      last_id   <= 1'b1;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_sel  <= win_id ? sel1 : sel0;
            op_a    <= win_id ? a1 : a0;
            op_b    <= win_id ? b1 : b0;
            last_id <= win_id;
            state   <= EXEC;
          end
        end
        EXEC: begin
          res_data  <= alu_out;
          res_id    <= last_id;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Arbitrates one 32-bit ALU between two requesters (for example the EX-stage datapath and a debug/self-test port). The block grants one request at a time and registers the operands. It executes the operation on an internal ALU instance and holds the tagged result until the consumer accepts it. It sits between the requesters and the ALU; the ALU is instantiated inside the block.

## Interface

Parameters:
- FIXED_PRIO, default 0: 0 selects round-robin arbitration; 1 makes requester 0 always win.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0 / req1  input  1  request from requester 0 / 1. Held with operands until granted.
- sel0 / sel1  input  3  ALU operation code of requester 0 / 1.
- a0, b0 / a1, b1  input  32  operands of requester 0 / 1.
- gnt0 / gnt1  output  1  combinational grant. Operands are captured at the rising edge where grant is high.
- busy  output  1  high whenever state is not IDLE.
- res_valid  output  1  result available.
- res_id  output  1  index of the requester that owns res_data.
- res_data  output  32  ALU result.
- res_ready  input  1  consumer accepts the result at a rising edge where res_valid is high.

## Operation

- FSM states: IDLE, EXEC, RESP.

**IDLE**
- If req0 or req1 is high, assert exactly one gnt for the winner, combinationally.
- At the edge: capture the winner's sel/A/B into op registers, set last_id to the winner, and go to EXEC.
- With no request, stay in IDLE.

**EXEC**
- The internal ALU computes from the op registers. No grant is asserted.
- At the edge: res_data takes the ALU output, res_id takes last_id, res_valid goes to 1, and state goes to RESP.

**RESP**
- res_valid, res_id and res_data are held stable. No grant is asserted.
- At an edge with res_ready=1: res_valid goes to 0 and state goes to IDLE.
- res_data and res_id keep their last value after acceptance.

**Arbitration**
- Single request: that requester wins.
- Both requesting with FIXED_PRIO=0: winner is the inverse of last_id, i.e. the requester not served last.
- Both requesting with FIXED_PRIO=1: requester 0 wins.
- A losing requester keeps its request asserted and wins the next IDLE cycle under round-robin.

**ALU operation codes** (32-bit, unsigned wrap):
- 000: A+B, mod 2^32.
- 001: A−B, mod 2^32.
- 010: A|B.
- 011: 1 if A==B, else 0.
- 100: A&B.
- 101: 1 if A[31]==0 and exactly one bit of A[30:0] is set, else 0. B is ignored.
- 110, 111: 0.

**Reset**
- While reset=0, asynchronously force: state IDLE, res_valid 0, res_id 0, res_data 0, op registers 0, last_id 1 (so requester 0 wins first).
- gnt0 and gnt1 are 0 while reset is low.
- Reset mid-operation, in EXEC or RESP, drops the operation silently. The requester must re-request.

## Timing

- Grant to res_valid: exactly 2 edges. Grant is seen at edge N, then EXEC at edge N+1 produces res_valid=1 after N+1.
- Minimum issue interval: 3 cycles (IDLE, EXEC, RESP with res_ready already high).
- Each additional cycle that res_ready is low adds one cycle to the interval.
- req may drop the cycle after its grant. Operand changes after the grant edge do not affect the result.
- Requests asserted during EXEC/RESP are ignored until IDLE. They are not queued internally.

## Test plan

1. **Single add.** After reset, req0=1, sel0=000, a0=5, b0=7, res_ready=1.
   - gnt0=1 in the first cycle.
   - res_valid=1 two edges later with res_data=12, res_id=0.
   - busy is low again one cycle after acceptance.
2. **Round-robin.** FIXED_PRIO=0, req0 and req1 held high continuously, res_ready=1.
   - Grant order is 0,1,0,1.
   - res_id sequence is 0,1,0,1, one result every 3 cycles.
   - With FIXED_PRIO=1 under the same stimulus, every grant goes to requester 0.
3. **Arithmetic edges.**
   - sub 0−1 gives 0xFFFFFFFF.
   - add 0xFFFFFFFF+1 gives 0.
   - eq(3,3) gives 1; eq(3,4) gives 0.
   - sel=111 gives 0.
4. **Op 101 (power-of-two check).**
   - A=0x00000040 gives 1.
   - A=0x80000040 gives 0.
   - A=0x00000003 gives 0.
   - A=0x00000000 gives 0.
   - A=0x40000000 gives 1.
5. **Backpressure.** Hold res_ready=0 for 5 cycles in RESP with req1 high.
   - res_valid, res_data and res_id stay constant; gnt1 stays 0.
   - After res_ready=1, gnt1 is asserted in the following IDLE cycle.
6. **Reset mid-operation.** Pull reset low during EXEC.
   - res_valid=0, res_data=0 and busy=0 immediately, without waiting for a clock edge.
   - After release with both requests high, the first grant goes to requester 0.
